// File: rtl/line_buffer_col_feeder.sv
// Raster-to-column front end: keeps MASK_WIDTH-1 previous rows and emits, per
// accepted pixel, the vertical column of MASK_WIDTH pixels ending at that pixel.
module line_buffer_col_feeder #(
    parameter int PIX_BIT    = 8,
    parameter int MASK_WIDTH = 7,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            sof,
    input  logic                            pix_in_valid,
    input  logic [PIX_BIT-1:0]              pix_in,
    output logic [PIX_BIT*MASK_WIDTH-1:0]   col_out,
    output logic                            col_out_valid,
    output logic [$clog2(IMG_HEIGHT)-1:0]   out_row,
    output logic [$clog2(IMG_WIDTH)-1:0]    out_col,
    output logic                            win_valid,
    output logic                            frame_done
);

    localparam int RW   = $clog2(IMG_HEIGHT);
    localparam int CW   = $clog2(IMG_WIDTH);
    localparam int NBUF = MASK_WIDTH - 1;

    localparam logic [RW-1:0] ROW_FULL = RW'(MASK_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN} state_t;

    state_t                          r_state;
    logic [RW-1:0]                   r_row_cnt;
    logic [CW-1:0]                   r_col_cnt;
    logic [PIX_BIT*MASK_WIDTH-1:0]   r_col_out;
    logic                            r_col_out_valid;
    logic [RW-1:0]                   r_out_row;
    logic [CW-1:0]                   r_out_col;
    logic                            r_win_valid;
    logic                            r_frame_done;

    // Buffer k holds row r-1-k; never reset, stale rows are masked by win_valid.
    logic [PIX_BIT-1:0]              r_lbuf [NBUF][IMG_WIDTH];

    logic                            w_accept;
    logic [RW-1:0]                   w_row;
    logic [CW-1:0]                   w_col;
    logic [RW-1:0]                   w_row_next;
    logic [RW-1:0]                   w_row_adv;
    logic                            w_col_last;
    logic                            w_frame_last;
    logic [PIX_BIT*MASK_WIDTH-1:0]   w_column;

    // A qualified sof restarts the frame from any state, so it overrides the counters.
    assign w_accept     = pix_in_valid && (sof || (r_state != S_IDLE));
    assign w_row        = sof ? '0 : r_row_cnt;
    assign w_col        = sof ? '0 : r_col_cnt;
    assign w_row_next   = w_row + 1'b1;
    assign w_col_last   = (w_col == COL_LAST);
    assign w_frame_last = w_col_last && (w_row == ROW_LAST);
    assign w_row_adv    = w_col_last ? w_row_next : w_row;

    always_comb begin
        w_column = '0;
        w_column[PIX_BIT-1:0] = pix_in;
        for (int unsigned k = 0; k < NBUF; k++) begin
            w_column[PIX_BIT*(k+1) +: PIX_BIT] = r_lbuf[k][w_col];
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lbuf[0][w_col] <= pix_in;
            for (int unsigned k = 1; k < NBUF; k++) begin
                r_lbuf[k][w_col] <= r_lbuf[k-1][w_col];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= S_IDLE;
            r_row_cnt       <= '0;
            r_col_cnt       <= '0;
            r_col_out       <= '0;
            r_col_out_valid <= 1'b0;
            r_out_row       <= '0;
            r_out_col       <= '0;
            r_win_valid     <= 1'b0;
            r_frame_done    <= 1'b0;
        end else begin
            r_col_out_valid <= 1'b0;
            r_win_valid     <= 1'b0;
            r_frame_done    <= 1'b0;
            if (w_accept) begin
                r_col_out       <= w_column;
                r_col_out_valid <= 1'b1;
                r_out_row       <= w_row;
                r_out_col       <= w_col;
                r_win_valid     <= (w_row >= ROW_FULL);
                if (w_frame_last) begin
                    r_frame_done <= 1'b1;
                    r_state      <= S_IDLE;
                    r_row_cnt    <= '0;
                    r_col_cnt    <= '0;
                end else begin
                    r_row_cnt <= w_row_adv;
                    r_col_cnt <= w_col_last ? '0 : w_col + 1'b1;
                    r_state   <= (w_row_adv >= ROW_FULL) ? S_RUN : S_FILL;
                end
            end
        end
    end

    assign col_out       = r_col_out;
    assign col_out_valid = r_col_out_valid;
    assign out_row       = r_out_row;
    assign out_col       = r_out_col;
    assign win_valid     = r_win_valid;
    assign frame_done    = r_frame_done;

endmodule

// File: tb/tb_line_buffer_col_feeder.sv
// Scoreboard bench for line_buffer_col_feeder on a small 8x10 image, 7-row mask.
module tb_line_buffer_col_feeder;

    localparam int PB = 8;
    localparam int MW = 7;
    localparam int IW = 8;
    localparam int IH = 10;

    logic           clk;
    logic           reset;
    logic           sof;
    logic           pix_in_valid;
    logic [PB-1:0]  pix_in;
    logic [PB*MW-1:0] col_out;
    logic           col_out_valid;
    logic [3:0]     out_row;
    logic [2:0]     out_col;
    logic           win_valid;
    logic           frame_done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic            v;
        logic [PB*MW-1:0] col;
        logic [PB*MW-1:0] mask;
        logic [3:0]      row;
        logic [2:0]      cl;
        logic            win;
        logic            done;
    } exp_t;

    exp_t sb[$];

    line_buffer_col_feeder #(
        .PIX_BIT(PB),
        .MASK_WIDTH(MW),
        .IMG_WIDTH(IW),
        .IMG_HEIGHT(IH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sof(sof),
        .pix_in_valid(pix_in_valid),
        .pix_in(pix_in),
        .col_out(col_out),
        .col_out_valid(col_out_valid),
        .out_row(out_row),
        .out_col(out_col),
        .win_valid(win_valid),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [PB-1:0] gen(input int seed, input int r, input int c);
        return PB'((r * 8 + c + seed) & 255);
    endfunction

    // Streams one frame (optionally with gaps, a mid-frame sof and an early stop),
    // checking every output cycle against the scoreboard.
    task automatic test_frame(input int seed_a, input int seed_b, input bit gaps,
                              input int rs_row, input int rs_col, input int stop_p,
                              output int n_valid, output int n_win, output int n_done,
                              output int done_row, output int done_col);
        int r, c, seed, gap_left;
        bit first, restarted, fin, sof_now;
        logic [3:0] hr;
        logic [2:0] hc;
        exp_t e, x;
        r = 0; c = 0; seed = seed_a; gap_left = 0;
        first = 1'b1; restarted = 1'b0; fin = 1'b0;
        hr = '0; hc = '0;
        n_valid = 0; n_win = 0; n_done = 0; done_row = -1; done_col = -1;
        sb.delete();
        for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
            @(negedge clk);
            if (sb.size() > 0) begin
                x = sb.pop_front();
                checks++;
                if (col_out_valid !== x.v) begin
                    errors++;
                    $display("FAIL valid cyc=%0d got=%b exp=%b", cyc, col_out_valid, x.v);
                end
                checks++;
                if (win_valid !== x.win) begin
                    errors++;
                    $display("FAIL win_valid cyc=%0d got=%b exp=%b", cyc, win_valid, x.win);
                end
                checks++;
                if (frame_done !== x.done) begin
                    errors++;
                    $display("FAIL frame_done cyc=%0d got=%b exp=%b", cyc, frame_done, x.done);
                end
                checks++;
                if (out_row !== x.row || out_col !== x.cl) begin
                    errors++;
                    $display("FAIL position cyc=%0d got=(%0d,%0d) exp=(%0d,%0d)",
                             cyc, out_row, out_col, x.row, x.cl);
                end
                if (x.v) begin
                    checks++;
                    if ((col_out & x.mask) !== (x.col & x.mask)) begin
                        errors++;
                        $display("FAIL col_out (%0d,%0d) got=%h exp=%h mask=%h",
                                 x.row, x.cl, col_out, x.col, x.mask);
                    end
                end
                if (col_out_valid === 1'b1) n_valid++;
                if (win_valid === 1'b1) n_win++;
                if (frame_done === 1'b1) begin
                    n_done++;
                    done_row = int'(out_row);
                    done_col = int'(out_col);
                end
            end
            if (gap_left > 0) begin
                gap_left--;
                pix_in_valid = 1'b0;
                sof          = 1'b0;
                pix_in       = PB'($urandom);
                e.v = 1'b0; e.col = '0; e.mask = '0; e.row = hr; e.cl = hc;
                e.win = 1'b0; e.done = 1'b0;
                sb.push_back(e);
            end else begin
                sof_now = first;
                if (!first && !restarted && r == rs_row && c == rs_col) begin
                    restarted = 1'b1;
                    r = 0; c = 0; seed = seed_b;
                    sof_now = 1'b1;
                end
                if (r >= IH || (r * IW + c) >= stop_p) begin
                    pix_in_valid = 1'b0;
                    sof          = 1'b0;
                    fin          = 1'b1;
                end else begin
                    pix_in_valid = 1'b1;
                    sof          = sof_now;
                    pix_in       = gen(seed, r, c);
                    e.v = 1'b1; e.col = '0; e.mask = '0;
                    for (int j = 0; j < MW; j++) begin
                        if (r >= j) begin
                            e.col[PB*j +: PB]  = gen(seed, r - j, c);
                            e.mask[PB*j +: PB] = '1;
                        end
                    end
                    e.row  = 4'(r);
                    e.cl   = 3'(c);
                    e.win  = (r >= MW - 1);
                    e.done = (r == IH - 1) && (c == IW - 1);
                    sb.push_back(e);
                    hr = 4'(r); hc = 3'(c);
                    first = 1'b0;
                    c++;
                    if (c == IW) begin
                        c = 0;
                        r++;
                    end
                    gap_left = gaps ? 2 : 0;
                end
            end
        end
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL stream_timeout got=unfinished exp=finished");
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; sof = 1'b0; pix_in_valid = 1'b0; pix_in = '0;
        #1 reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if ({col_out, col_out_valid, out_row, out_col, win_valid, frame_done} !== '0) begin
                errors++;
                $display("FAIL reset_outputs i=%0d got col=%h v=%b row=%0d col=%0d win=%b done=%b exp=all zero",
                         i, col_out, col_out_valid, out_row, out_col, win_valid, frame_done);
            end
            pix_in_valid = 1'($urandom_range(0, 1));
            sof          = 1'($urandom_range(0, 1));
            pix_in       = PB'($urandom);
        end
        @(negedge clk);
        reset = 1'b1; sof = 1'b0; pix_in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pix_in = PB'($urandom);
            @(negedge clk);
            checks++;
            if (col_out_valid !== 1'b0 || win_valid !== 1'b0 || frame_done !== 1'b0) begin
                errors++;
                $display("FAIL idle_no_sof i=%0d got v=%b win=%b done=%b exp=0",
                         i, col_out_valid, win_valid, frame_done);
            end
        end
        pix_in_valid = 1'b0;
    endtask

    task automatic test_continuous();
        int nv, nw, nd, dr, dc;
        test_frame(0, 0, 1'b0, -1, -1, IW * IH + 1, nv, nw, nd, dr, dc);
        checks++;
        if (nv != 80) begin errors++; $display("FAIL cont_valid_count got=%0d exp=80", nv); end
        checks++;
        if (nw != 32) begin errors++; $display("FAIL cont_win_count got=%0d exp=32", nw); end
        checks++;
        if (nd != 1 || dr != 9 || dc != 7) begin
            errors++;
            $display("FAIL cont_frame_done got n=%0d at (%0d,%0d) exp n=1 at (9,7)", nd, dr, dc);
        end
        // Frame ended: the block must be idle and drop a pixel without sof.
        pix_in_valid = 1'b1; sof = 1'b0; pix_in = 8'hA5;
        @(negedge clk);
        pix_in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (col_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_frame_drop got v=%b exp=0", col_out_valid);
        end
    endtask

    task automatic test_gaps();
        int nv, nw, nd, dr, dc;
        test_frame(0, 0, 1'b1, -1, -1, IW * IH + 1, nv, nw, nd, dr, dc);
        checks++;
        if (nv != 80 || nw != 32) begin
            errors++;
            $display("FAIL gap_counts got valid=%0d win=%0d exp valid=80 win=32", nv, nw);
        end
        checks++;
        if (nd != 1 || dr != 9 || dc != 7) begin
            errors++;
            $display("FAIL gap_frame_done got n=%0d at (%0d,%0d) exp n=1 at (9,7)", nd, dr, dc);
        end
    endtask

    task automatic test_restart();
        int nv, nw, nd, dr, dc;
        test_frame(17, 90, 1'b0, 8, 2, IW * IH + 1, nv, nw, nd, dr, dc);
        checks++;
        if (nv != 146) begin errors++; $display("FAIL restart_valid_count got=%0d exp=146", nv); end
        checks++;
        if (nw != 50) begin errors++; $display("FAIL restart_win_count got=%0d exp=50", nw); end
        checks++;
        if (nd != 1 || dr != 9 || dc != 7) begin
            errors++;
            $display("FAIL restart_frame_done got n=%0d at (%0d,%0d) exp n=1 at (9,7)", nd, dr, dc);
        end
    endtask

    task automatic test_midframe_reset();
        int nv, nw, nd, dr, dc;
        test_frame(3, 3, 1'b0, -1, -1, 7 * IW + 3, nv, nw, nd, dr, dc);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({col_out, col_out_valid, out_row, out_col, win_valid, frame_done} !== '0) begin
            errors++;
            $display("FAIL async_reset got col=%h v=%b row=%0d col=%0d win=%b done=%b exp=all zero",
                     col_out, col_out_valid, out_row, out_col, win_valid, frame_done);
        end
        @(negedge clk);
        reset = 1'b1;
        test_frame(200, 200, 1'b0, -1, -1, 7 * IW, nv, nw, nd, dr, dc);
        checks++;
        if (nv != 56 || nw != 8 || nd != 0) begin
            errors++;
            $display("FAIL after_reset_counts got valid=%0d win=%0d done=%0d exp 56 8 0", nv, nw, nd);
        end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_gaps();
        test_restart();
        test_midframe_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/line_buffer_col_feeder.md
# line_buffer_col_feeder

Raster-to-column front end for the spatial filter pipeline. Accepts one pixel per valid cycle in raster order and stores the previous MASK_WIDTH-1 image rows in internal line buffers. Each accepted pixel produces one vertical column of MASK_WIDTH pixels: the new pixel plus the same-column pixels from the rows above it. The packed column drives the filter-mask window's single-column pixel input, together with position and window-valid qualifiers.

## Interface
- PIX_BIT, 8, bits per pixel
- MASK_WIDTH, 7, mask height; the block keeps MASK_WIDTH-1 line buffers
- IMG_WIDTH, 640, pixels per row (>= MASK_WIDTH)
- IMG_HEIGHT, 480, rows per frame (>= MASK_WIDTH)
- clk  in  1  single clock; all logic rising-edge
- reset  in  1  asynchronous, active-low reset
- sof  in  1  start of frame; qualified by pix_in_valid, marks pixel (row 0, col 0)
- pix_in_valid  in  1  pix_in carries a pixel this cycle
- pix_in  in  PIX_BIT  incoming raster pixel
- col_out  out  PIX_BIT*MASK_WIDTH  packed column; slice j = [PIX_BIT*(j+1)-1:PIX_BIT*j] holds the pixel from row (r-j), same column
- col_out_valid  out  1  col_out updated this cycle
- out_row  out  clog2(IMG_HEIGHT)  row r of the emitted column
- out_col  out  clog2(IMG_WIDTH)  column of the emitted column
- win_valid  out  1  col_out_valid and out_row >= MASK_WIDTH-1 (all slices are real image data)
- frame_done  out  1  one-cycle pulse with the last column of the frame

## Operation
- Storage: MASK_WIDTH-1 line buffers of IMG_WIDTH x PIX_BIT each. Buffer k holds row r-1-k. Contents are not reset.
- Accepted pixel at column c, current row r:
  - Read buf[k][c] for every k.
  - col_out slice 0 = pix_in; slice k+1 = buf[k][c].
  - Write buf[0][c] = pix_in and buf[k][c] = old buf[k-1][c]. Read-before-write at the same address.
- Counters:
  - col_cnt increments per accepted pixel and wraps from IMG_WIDTH-1 to 0.
  - On that wrap, row_cnt increments.
- States:
  - IDLE: waiting for a frame. Pixels without sof are dropped: no output, no buffer write.
  - FILL: row_cnt < MASK_WIDTH-1. Columns are emitted with win_valid=0.
  - RUN: row_cnt >= MASK_WIDTH-1. Columns are emitted with win_valid=1.
- Transitions:
  - IDLE→FILL on pix_in_valid&sof; that pixel is processed as row 0, col 0.
  - FILL→RUN when row_cnt reaches MASK_WIDTH-1.
  - RUN→IDLE after the pixel at (IMG_HEIGHT-1, IMG_WIDTH-1) is accepted; frame_done pulses with that column.
- sof while in FILL or RUN: the frame restarts. That pixel is row 0, col 0, state goes to FILL, and no frame_done is issued. Stale buffer data is masked by win_valid=0 until row MASK_WIDTH-1.
- sof without pix_in_valid: ignored.
- Gaps (pix_in_valid=0): counters, buffers and col_out hold; col_out_valid=0.
- Horizontal borders are not handled here. Downstream uses out_col to qualify the window.

## Timing
- Latency: 1 cycle. Pixel accepted at edge N → col_out/col_out_valid/out_row/out_col/win_valid/frame_done registered and visible after edge N+1.
- Throughput: one pixel per cycle, no backpressure.
- Reset (reset=0, asynchronous) forces these values immediately:
  - Outputs: col_out=0, col_out_valid=0, out_row=0, out_col=0, win_valid=0, frame_done=0.
  - Internal: state IDLE, counters 0.
- Reset assertion mid-frame aborts the frame. After release, a new sof is required.
- Line buffers may be inferred block RAM with a synchronous read. In that case the read address is computed one cycle early so external latency stays 1 cycle.

## Test plan
- Reset: hold reset=0 with random inputs.
  - All outputs must be 0.
  - After release, pixels without sof must produce no col_out_valid.
- Fill/data check (MASK_WIDTH=7, IMG_WIDTH=8, IMG_HEIGHT=10, pixel=(row*8+col)&0xFF, continuous stream):
  - Input (6,3): slice j = (6-j)*8+3; out_row=6, out_col=3, win_valid=1.
  - Input (5,7): win_valid=0.
- Count check over one frame of the above:
  - 80 col_out_valid pulses.
  - 32 win_valid pulses.
  - Exactly one frame_done, on out_row=9, out_col=7.
  - State returns to IDLE; a following non-sof pixel is dropped.
- Gaps: same frame with pix_in_valid toggling 1,0,0,1…
  - Column data and positions must be identical to the continuous run.
  - No col_out_valid on gap cycles.
- sof at row 8, col 2: the next emitted column has out_row=0, out_col=0, win_valid=0, and no frame_done. The first win_valid appears at new row 6.
- Async reset at row 7 mid-frame: outputs are 0 within the same cycle. Then a new sof frame must produce the correct data at row 6.
